// File: rtl/ysyx_25020047_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// One operation in flight; the result is held until the consumer takes it.
module ysyx_25020047_mdu #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake: a request transfers on a rising edge where in_valid & in_ready & !flush;
    // a result transfers on a rising edge where out_valid & out_ready. Producers hold
    // valid and payload stable until the transfer; ready never depends on valid.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int               CNT_W    = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg1_q, neg2_q, dz_q, ovf_q;
    logic [XLEN-1:0]     src1_q;
    logic [TAG_W-1:0]    tag_q;
    logic [XLEN-1:0]     result_q;
    logic [TAG_W-1:0]    tag_out_q;

    logic                load, iter, fin;

    // ---------------- request decode ----------------
    logic                accept;
    logic                sgn1_in, sgn2_in, neg1_in, neg2_in;
    logic [XLEN-1:0]     mag1, mag2;
    logic                dz_in, ovf_in;

    assign accept  = in_valid & (state_q == S_IDLE) & ~flush;
    assign sgn1_in = (op == 3'd0) | (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
    assign sgn2_in = (op == 3'd0) | (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
    assign neg1_in = sgn1_in & src1[XLEN-1];
    assign neg2_in = sgn2_in & src2[XLEN-1];
    assign mag1    = neg1_in ? (~src1 + 1'b1) : src1;
    assign mag2    = neg2_in ? (~src2 + 1'b1) : src2;
    assign dz_in   = op[2] & (src2 == '0);
    assign ovf_in  = ((op == 3'd4) | (op == 3'd6)) & (src1 == MIN_VAL) & (src2 == ONES);

    // ---------------- one iteration ----------------
    // acc_q = {hi, lo}: mul keeps partial product in hi and multiplier in lo;
    // div keeps partial remainder in hi and dividend/quotient in lo.
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift, div_diff;
    logic [2*XLEN-1:0]   div_next;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, a_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    // ---------------- sign fix-up and selection ----------------
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s, rem_s;
    logic [XLEN-1:0]     final_val;

    assign prod_s = (neg1_q ^ neg2_q) ? (~acc_q + 1'b1) : acc_q;
    assign quo_s  = (neg1_q ^ neg2_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    assign rem_s  = neg1_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        final_val = '0;
        case (op_q)
            3'd0:          final_val = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          final_val = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: begin
                if (dz_q)       final_val = ONES;
                else if (ovf_q) final_val = MIN_VAL;
                else            final_val = quo_s;
            end
            default: begin
                if (dz_q)       final_val = src1_q;
                else if (ovf_q) final_val = '0;
                else            final_val = rem_s;
            end
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // CALC spends XLEN iteration cycles plus one fix-up cycle (cnt == XLEN);
    // a special case skips straight to the fix-up cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        iter    = 1'b0;
        fin     = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end
                end
                S_CALC: begin
                    if (cnt_q == CNT_LAST) begin
                        fin     = 1'b1;
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else if (FAST_ZERO && (dz_q || ovf_q)) begin
                        cnt_d = CNT_LAST;
                    end else begin
                        iter  = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            acc_q     <= '0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            src1_q    <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            if (load) begin
                op_q   <= op;
                a_q    <= op[2] ? mag2 : mag1;
                acc_q  <= {{XLEN{1'b0}}, (op[2] ? mag1 : mag2)};
                neg1_q <= neg1_in;
                neg2_q <= neg2_in;
                dz_q   <= dz_in;
                ovf_q  <= ovf_in;
                src1_q <= src1;
                tag_q  <= tag_in;
            end
            if (iter) acc_q <= op_q[2] ? div_next : mul_next;
            if (fin) begin
                result_q  <= final_val;
                tag_out_q <= tag_q;
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign tag_out   = tag_out_q;
    assign dbg_state = state_q;

endmodule
